// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared encodings for the MEM-stage load/store path.
//   DATA_WIDTH      memory word width (fixed at 32 for MIPS)
//   SIZE_*          i_size encodings (2'b10 is illegal)
//   mau_state_e     mem_access_unit FSM states
//   mau_req_t       request fields latched when a request is accepted
package mips_mem_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_RMW_MERGE = 2'd2
  } mau_state_e;

  typedef struct packed {
    logic [1:0]            off;
    logic [1:0]            size;
    logic                  uns;
    logic [DATA_WIDTH-1:0] wdata;
  } mau_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational little-endian lane handling.
//   i_offset    byte offset addr[1:0]
//   i_size      access size (SIZE_BYTE / SIZE_HALF / SIZE_WORD)
//   i_unsigned  zero-extend load result when 1, sign-extend when 0
//   i_word      word read from memory
//   i_wdata     right-aligned store data
//   o_load      extracted and extended load result
//   o_merged    i_word with the addressed lane replaced by store data
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]            i_offset,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_load,
  output logic [DATA_WIDTH-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // byte k at [8k+7:8k]; half h (= offset[1]) at [16h+15:16h]
  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

  always_comb begin
    o_load = i_word;
    case (i_size)
      SIZE_BYTE: o_load = {{(DATA_WIDTH-8){~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: o_load = {{(DATA_WIDTH-16){~i_unsigned & w_half[15]}}, w_half};
      default:   o_load = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_wdata;
    case (i_size)
      SIZE_BYTE: begin
        o_merged = i_word;
        o_merged[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
      end
      SIZE_HALF: begin
        o_merged = i_word;
        o_merged[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for the Data_memory port.
// Loads take two cycles (address, then extract); SB/SH are read-modify-write;
// SW writes in the accept cycle without stalling.
//   i_clk, i_reset        clock, async active-high reset
//   i_valid .. i_wdata    request from the MEM stage (sampled in IDLE only)
//   o_mem_addr/wdata/we   word port toward Data_memory
//   i_mem_rdata           memory read data, one cycle after the address
//   o_rdata               registered, extended load result
//   o_done / o_error      one-cycle completion / bad-request pulses
//   o_stall               combinational pipeline hold
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_we,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [31:0]           o_rdata,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_stall
);
  import mips_mem_pkg::*;

  mau_state_e            r_state, w_state_nxt;
  mau_req_t              r_req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_rdata;
  logic                  r_done, r_error;

  logic        w_misalign, w_req_err, w_idle, w_acc;
  logic        w_acc_ld, w_acc_sw, w_acc_rmw, w_we;
  logic [31:0] w_load, w_merged;
  logic        w_unused;

  // address bits above the memory size are dropped, so accesses wrap
  assign w_unused = &{1'b0, i_addr[31:ADDR_WIDTH+2]};

  always_comb begin
    w_misalign = 1'b0;
    case (i_size)
      SIZE_BYTE: w_misalign = 1'b0;
      SIZE_HALF: w_misalign = i_addr[0];
      SIZE_WORD: w_misalign = |i_addr[1:0];
      default:   w_misalign = 1'b1;
    endcase
  end

  // a request with neither read nor write is a NOP and never errors
  assign w_req_err = (i_mem_read | i_mem_write) & (w_misalign | (i_mem_read & i_mem_write));
  assign w_idle    = (r_state == ST_IDLE);
  assign w_acc     = w_idle & i_valid & ~w_req_err;
  assign w_acc_ld  = w_acc & i_mem_read;
  assign w_acc_sw  = w_acc & i_mem_write & (i_size == SIZE_WORD);
  assign w_acc_rmw = w_acc & i_mem_write & (i_size != SIZE_WORD);

  mem_lane_align u_align (
    .i_offset   (r_req.off),
    .i_size     (r_req.size),
    .i_unsigned (r_req.uns),
    .i_word     (i_mem_rdata),
    .i_wdata    (r_req.wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_comb begin
    w_state_nxt = r_state;
    o_mem_addr  = i_addr[ADDR_WIDTH+1:2];
    o_mem_wdata = i_wdata;
    w_we        = 1'b0;
    o_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_we    = w_acc_sw;
        o_stall = w_acc_ld | w_acc_rmw;
        if (w_acc_ld)       w_state_nxt = ST_LOAD_WAIT;
        else if (w_acc_rmw) w_state_nxt = ST_RMW_MERGE;
      end
      ST_LOAD_WAIT: begin
        o_mem_addr  = r_addr;
        o_mem_wdata = r_req.wdata;
        o_stall     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_RMW_MERGE: begin
        o_mem_addr  = r_addr;
        o_mem_wdata = w_merged;
        w_we        = 1'b1;
        o_stall     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // reset must block the write even in the cycle it is raised
  assign o_mem_we = w_we & ~i_reset;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_addr  <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // both non-idle states finish their access this cycle
      r_done  <= w_acc_sw | ~w_idle;
      r_error <= w_idle & i_valid & w_req_err;
      if (w_acc) begin
        r_addr <= i_addr[ADDR_WIDTH+1:2];
        r_req  <= '{off: i_addr[1:0], size: i_size, uns: i_unsigned, wdata: i_wdata};
      end
      if (r_state == ST_LOAD_WAIT) r_rdata <= w_load;
    end
  end

  assign o_rdata = r_rdata;
  assign o_done  = r_done;
  assign o_error = r_error;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int AW   = 11;
  localparam int NW   = 2048;
  localparam int MAXC = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid, i_mem_read, i_mem_write, i_unsigned;
  logic [1:0]    i_size;
  logic [31:0]   i_addr, i_wdata;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata, mem_rdata, o_rdata;
  logic          o_mem_we, o_done, o_error, o_stall;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_size(i_size), .i_unsigned(i_unsigned),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .i_mem_rdata(mem_rdata),
    .o_rdata(o_rdata), .o_done(o_done), .o_error(o_error), .o_stall(o_stall)
  );

  // Data_memory stand-in: synchronous read-first word RAM
  logic [31:0]   dmem [NW];
  logic [31:0]   ref_mem [NW];
  logic          init_en = 1'b0;
  logic [AW-1:0] init_a;
  logic [31:0]   init_d;
  always @(posedge clk) begin
    if (init_en)       dmem[init_a] <= init_d;
    else if (o_mem_we) dmem[o_mem_addr] <= o_mem_wdata;
    mem_rdata <= dmem[o_mem_addr];
  end

  typedef struct {
    bit          v, rd, wr, uns;
    logic [1:0]  sz;
    logic [31:0] a, wd;
  } req_t;

  req_t        rq[$];
  int          n_chk = 0, n_pass = 0, ncyc;
  logic [31:0] model_rdata;
  logic [3:0]  e_vec[MAXC], o_vec[MAXC];        // {stall, we, done, error}
  logic [31:0] e_rdata[MAXC], obs_rdata[MAXC];
  bit          e_addr_v[MAXC];
  logic [AW-1:0] e_addr[MAXC], obs_addr[MAXC];

  function automatic req_t mk(bit rd, bit wr, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd);
    req_t r;
    r.v = 1'b1; r.rd = rd; r.wr = wr; r.sz = sz; r.uns = uns; r.a = a; r.wd = wd;
    return r;
  endfunction

  function automatic bit req_err(req_t r);
    if (!(r.rd || r.wr)) return 1'b0;
    return (r.rd && r.wr) || (r.sz == 2'b10) || (r.sz == 2'b01 && r.a[0]) ||
           (r.sz == 2'b11 && r.a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] load_val(logic [31:0] w, logic [1:0] sz, bit uns, logic [1:0] off);
    logic [31:0] v;
    if (sz == 2'b11) return w;
    if (sz == 2'b00) begin
      v = (w >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else begin
      v = (w >> (16 * off[1])) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_val(logic [31:0] w, logic [1:0] sz, logic [1:0] off, logic [31:0] d);
    logic [31:0] mask, sh;
    if (sz == 2'b11) return d;
    if (sz == 2'b00) begin
      mask = 32'hFF << (8 * off);
      sh   = (d & 32'hFF) << (8 * off);
    end else begin
      mask = 32'hFFFF << (16 * off[1]);
      sh   = (d & 32'hFFFF) << (16 * off[1]);
    end
    return (w & ~mask) | sh;
  endfunction

  // Builds the expected per-cycle trace from the request list, then drives
  // the requests back to back and records what the DUT does each cycle.
  task automatic run_seq();
    int          st[$], ln[$];
    int          t = 0, k = 0;
    bit          ld_at[MAXC], b_st[MAXC], b_we[MAXC], b_dn[MAXC], b_er[MAXC];
    logic [31:0] ld_v[MAXC];
    logic [31:0] cur;
    for (int c = 0; c < MAXC; c++) begin
      ld_at[c] = 0; b_st[c] = 0; b_we[c] = 0; b_dn[c] = 0; b_er[c] = 0;
      ld_v[c] = '0; e_addr_v[c] = 0; e_addr[c] = '0;
    end
    foreach (rq[i]) begin
      req_t r;
      bit   er, act, lng;
      int   widx;
      r    = rq[i];
      er   = r.v && req_err(r);
      act  = r.v && !er && (r.rd || r.wr);
      lng  = act && (r.rd || r.sz != 2'b11);
      widx = int'(r.a[AW+1:2]);
      st.push_back(t);
      ln.push_back(lng ? 2 : 1);
      if (er) b_er[t+1] = 1;
      if (act) begin
        e_addr_v[t] = 1; e_addr[t] = r.a[AW+1:2];
        if (lng) begin b_st[t] = 1; b_st[t+1] = 1; b_dn[t+2] = 1; end
        else b_dn[t+1] = 1;
        if (r.rd) begin
          ld_at[t+2] = 1;
          ld_v[t+2]  = load_val(ref_mem[widx], r.sz, r.uns, r.a[1:0]);
        end else begin
          b_we[lng ? t+1 : t] = 1;
          ref_mem[widx] = store_val(ref_mem[widx], r.sz, r.a[1:0], r.wd);
        end
      end
      t += lng ? 2 : 1;
    end
    ncyc = t + 3;
    cur  = model_rdata;
    for (int c = 0; c < ncyc; c++) begin
      if (ld_at[c]) cur = ld_v[c];
      e_rdata[c] = cur;
      e_vec[c]   = {b_st[c], b_we[c], b_dn[c], b_er[c]};
    end
    model_rdata = cur;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      while (k < rq.size() && c >= st[k] + ln[k]) k++;
      if (k < rq.size()) begin
        i_valid = rq[k].v; i_mem_read = rq[k].rd; i_mem_write = rq[k].wr;
        i_size = rq[k].sz; i_unsigned = rq[k].uns; i_addr = rq[k].a; i_wdata = rq[k].wd;
      end else begin
        i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
      end
      #1;
      o_vec[c]     = {o_stall, o_mem_we, o_done, o_error};
      obs_rdata[c] = o_rdata;
      obs_addr[c]  = o_mem_addr;
    end
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    i_valid = 1'b1; i_mem_write = 1'b1; i_mem_read = 1'b0; i_size = 2'b11;
    i_addr = 32'h0; i_wdata = 32'hDEAD_BEEF; i_unsigned = 1'b0;
    #1;
    n_chk++; if (o_mem_we !== 1'b0) $display("FAIL reset_we got %b want 0", o_mem_we); else n_pass++;
    n_chk++; if (o_done !== 1'b0) $display("FAIL reset_done got %b want 0", o_done); else n_pass++;
    n_chk++; if (o_error !== 1'b0) $display("FAIL reset_error got %b want 0", o_error); else n_pass++;
    n_chk++; if (o_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", o_rdata); else n_pass++;
    @(negedge clk);
    n_chk++; if (dmem[0] !== ref_mem[0]) $display("FAIL reset_mem got %h want %h", dmem[0], ref_mem[0]); else n_pass++;
    i_valid = 1'b0; i_mem_write = 1'b0;
    rst = 1'b0;
    model_rdata = 32'h0;
    #1;
    n_chk++; if (o_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", o_stall); else n_pass++;
  endtask

  task automatic test_store_load();
    int mm = 0;
    rq.delete();
    rq.push_back(mk(0, 1, 2'b11, 0, 32'h4, 32'h1122_3344));  // t0
    rq.push_back(mk(1, 0, 2'b11, 0, 32'h4, 32'h0));          // t1, done t3
    rq.push_back(mk(0, 1, 2'b00, 0, 32'h6, 32'h0000_00AA));  // t3
    rq.push_back(mk(1, 0, 2'b00, 0, 32'h6, 32'h0));          // t5, done t7
    rq.push_back(mk(1, 0, 2'b00, 1, 32'h6, 32'h0));          // t7, done t9
    rq.push_back(mk(0, 1, 2'b01, 0, 32'h4, 32'h0000_8001));  // t9
    rq.push_back(mk(1, 0, 2'b01, 0, 32'h4, 32'h0));          // t11, done t13
    rq.push_back(mk(1, 0, 2'b01, 1, 32'h6, 32'h0));          // t13, done t15
    run_seq();
    for (int c = 0; c < ncyc; c++) begin
      n_chk++; if (o_vec[c] !== e_vec[c]) $display("FAIL ldst_ctl cyc%0d {stall,we,done,err} got %b want %b", c, o_vec[c], e_vec[c]); else n_pass++;
      n_chk++; if (obs_rdata[c] !== e_rdata[c]) $display("FAIL ldst_rdata cyc%0d got %h want %h", c, obs_rdata[c], e_rdata[c]); else n_pass++;
      if (e_addr_v[c]) begin
        n_chk++; if (obs_addr[c] !== e_addr[c]) $display("FAIL ldst_addr cyc%0d got %h want %h", c, obs_addr[c], e_addr[c]); else n_pass++;
      end
    end
    n_chk++; if (obs_rdata[3] !== 32'h1122_3344) $display("FAIL lw got %h want 11223344", obs_rdata[3]); else n_pass++;
    n_chk++; if (obs_rdata[7] !== 32'hFFFF_FFAA) $display("FAIL lb got %h want ffffffaa", obs_rdata[7]); else n_pass++;
    n_chk++; if (obs_rdata[9] !== 32'h0000_00AA) $display("FAIL lbu got %h want 000000aa", obs_rdata[9]); else n_pass++;
    n_chk++; if (obs_rdata[13] !== 32'hFFFF_8001) $display("FAIL lh got %h want ffff8001", obs_rdata[13]); else n_pass++;
    n_chk++; if (obs_rdata[15] !== 32'h0000_11AA) $display("FAIL lhu got %h want 000011aa", obs_rdata[15]); else n_pass++;
    n_chk++; if (dmem[1] !== 32'h11AA_8001) $display("FAIL word1 got %h want 11aa8001", dmem[1]); else n_pass++;
    for (int w = 0; w < NW; w++) if (dmem[w] !== ref_mem[w]) mm++;
    n_chk++; if (mm != 0) $display("FAIL ldst_mem got %0d bad words want 0", mm); else n_pass++;
  endtask

  task automatic test_errors();
    int mm = 0;
    rq.delete();
    rq.push_back(mk(1, 0, 2'b11, 0, 32'h2, 32'h0));
    rq.push_back(mk(0, 1, 2'b01, 0, 32'h5, 32'hFFFF));
    rq.push_back(mk(1, 0, 2'b10, 0, 32'h4, 32'h0));
    rq.push_back(mk(0, 1, 2'b10, 0, 32'h8, 32'h1234_5678));
    rq.push_back(mk(1, 1, 2'b11, 0, 32'h8, 32'h1234_5678));
    rq.push_back(mk(0, 0, 2'b11, 0, 32'h8, 32'h1234_5678));   // NOP
    run_seq();
    for (int c = 0; c < ncyc; c++) begin
      n_chk++; if (o_vec[c] !== e_vec[c]) $display("FAIL err_ctl cyc%0d {stall,we,done,err} got %b want %b", c, o_vec[c], e_vec[c]); else n_pass++;
      n_chk++; if (obs_rdata[c] !== e_rdata[c]) $display("FAIL err_rdata cyc%0d got %h want %h", c, obs_rdata[c], e_rdata[c]); else n_pass++;
    end
    for (int w = 0; w < NW; w++) if (dmem[w] !== ref_mem[w]) mm++;
    n_chk++; if (mm != 0) $display("FAIL err_mem got %0d bad words want 0", mm); else n_pass++;
  endtask

  task automatic test_wrap();
    int mm = 0;
    rq.delete();
    rq.push_back(mk(0, 1, 2'b11, 0, 32'h0000_2000, 32'hCAFE_0001));
    rq.push_back(mk(1, 0, 2'b11, 0, 32'h0000_0000, 32'h0));
    rq.push_back(mk(0, 1, 2'b11, 0, 32'hFFFF_FFFC, 32'hCAFE_07FF));
    rq.push_back(mk(1, 0, 2'b00, 1, 32'h0000_1FFF, 32'h0));
    run_seq();
    for (int c = 0; c < ncyc; c++) begin
      n_chk++; if (o_vec[c] !== e_vec[c]) $display("FAIL wrap_ctl cyc%0d {stall,we,done,err} got %b want %b", c, o_vec[c], e_vec[c]); else n_pass++;
      n_chk++; if (obs_rdata[c] !== e_rdata[c]) $display("FAIL wrap_rdata cyc%0d got %h want %h", c, obs_rdata[c], e_rdata[c]); else n_pass++;
      if (e_addr_v[c]) begin
        n_chk++; if (obs_addr[c] !== e_addr[c]) $display("FAIL wrap_addr cyc%0d got %h want %h", c, obs_addr[c], e_addr[c]); else n_pass++;
      end
    end
    n_chk++; if (obs_addr[0] !== 11'd0) $display("FAIL wrap_addr0 got %h want 0", obs_addr[0]); else n_pass++;
    for (int w = 0; w < NW; w++) if (dmem[w] !== ref_mem[w]) mm++;
    n_chk++; if (mm != 0) $display("FAIL wrap_mem got %0d bad words want 0", mm); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int mm = 0;
    rq.delete();
    rq.push_back(mk(0, 1, 2'b11, 0, 32'h10, 32'hA5A5_0010));
    rq.push_back(mk(1, 0, 2'b11, 0, 32'h10, 32'h0));
    rq.push_back(mk(0, 1, 2'b11, 0, 32'h14, 32'hA5A5_0014));
    rq.push_back(mk(0, 1, 2'b11, 0, 32'h18, 32'hA5A5_0018));
    rq.push_back(mk(0, 1, 2'b11, 0, 32'h1C, 32'hA5A5_001C));
    rq.push_back(mk(1, 0, 2'b11, 1, 32'h1C, 32'h0));
    rq.push_back(mk(0, 1, 2'b00, 0, 32'h1F, 32'h0000_0080));
    rq.push_back(mk(1, 0, 2'b00, 0, 32'h1F, 32'h0));
    run_seq();
    for (int c = 0; c < ncyc; c++) begin
      n_chk++; if (o_vec[c] !== e_vec[c]) $display("FAIL b2b_ctl cyc%0d {stall,we,done,err} got %b want %b", c, o_vec[c], e_vec[c]); else n_pass++;
      n_chk++; if (obs_rdata[c] !== e_rdata[c]) $display("FAIL b2b_rdata cyc%0d got %h want %h", c, obs_rdata[c], e_rdata[c]); else n_pass++;
      if (e_addr_v[c]) begin
        n_chk++; if (obs_addr[c] !== e_addr[c]) $display("FAIL b2b_addr cyc%0d got %h want %h", c, obs_addr[c], e_addr[c]); else n_pass++;
      end
    end
    for (int w = 0; w < NW; w++) if (dmem[w] !== ref_mem[w]) mm++;
    n_chk++; if (mm != 0) $display("FAIL b2b_mem got %0d bad words want 0", mm); else n_pass++;
  endtask

  task automatic test_random();
    int mm = 0;
    rq.delete();
    for (int i = 0; i < 150; i++) begin
      req_t r;
      int   kind, szp;
      kind = $urandom_range(0, 9);
      szp  = $urandom_range(0, 6);
      r.v  = (kind != 0); r.rd = 1'b0; r.wr = 1'b0;
      if (kind >= 1 && kind <= 4)      r.rd = 1'b1;
      else if (kind >= 5 && kind <= 8) r.wr = 1'b1;
      else begin r.rd = 1'($urandom_range(0, 1)); r.wr = 1'($urandom_range(0, 1)); end
      r.sz  = (szp < 2) ? 2'b00 : (szp < 4) ? 2'b01 : (szp < 6) ? 2'b11 : 2'b10;
      r.uns = 1'($urandom_range(0, 1));
      r.a   = ($urandom & 32'hFFFF_E000) | 32'($urandom_range(0, 31));
      if ($urandom_range(0, 4) != 0) begin
        if (r.sz == 2'b01) r.a[0] = 1'b0;
        if (r.sz == 2'b11) r.a[1:0] = 2'b00;
      end
      r.wd = $urandom;
      rq.push_back(r);
    end
    run_seq();
    for (int c = 0; c < ncyc; c++) begin
      n_chk++; if (o_vec[c] !== e_vec[c]) $display("FAIL rnd_ctl cyc%0d {stall,we,done,err} got %b want %b", c, o_vec[c], e_vec[c]); else n_pass++;
      n_chk++; if (obs_rdata[c] !== e_rdata[c]) $display("FAIL rnd_rdata cyc%0d got %h want %h", c, obs_rdata[c], e_rdata[c]); else n_pass++;
      if (e_addr_v[c]) begin
        n_chk++; if (obs_addr[c] !== e_addr[c]) $display("FAIL rnd_addr cyc%0d got %h want %h", c, obs_addr[c], e_addr[c]); else n_pass++;
      end
    end
    for (int w = 0; w < NW; w++) if (dmem[w] !== ref_mem[w]) mm++;
    n_chk++; if (mm != 0) $display("FAIL rnd_mem got %0d bad words want 0", mm); else n_pass++;
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    i_valid = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b1; i_size = 2'b00;
    i_unsigned = 1'b0; i_addr = 32'h21; i_wdata = 32'h5A;
    #1;
    n_chk++; if (o_stall !== 1'b1) $display("FAIL abort_stallN got %b want 1", o_stall); else n_pass++;
    @(negedge clk);
    #1;
    n_chk++; if (o_mem_we !== 1'b1) $display("FAIL abort_we_pre got %b want 1", o_mem_we); else n_pass++;
    rst = 1'b1; i_valid = 1'b0; i_mem_write = 1'b0;
    #1;
    n_chk++; if (o_mem_we !== 1'b0) $display("FAIL abort_we got %b want 0", o_mem_we); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_rdata = 32'h0;
    #1;
    n_chk++; if (o_done !== 1'b0) $display("FAIL abort_done got %b want 0", o_done); else n_pass++;
    n_chk++; if (o_stall !== 1'b0) $display("FAIL abort_stall got %b want 0", o_stall); else n_pass++;
    n_chk++; if (o_rdata !== 32'h0) $display("FAIL abort_rdata got %h want 0", o_rdata); else n_pass++;
    @(negedge clk);
    #1;
    n_chk++; if (o_done !== 1'b0) $display("FAIL abort_done2 got %b want 0", o_done); else n_pass++;
    n_chk++; if (dmem[8] !== ref_mem[8]) $display("FAIL abort_mem got %h want %h", dmem[8], ref_mem[8]); else n_pass++;
  endtask

  initial begin
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_size = 2'b00;
    i_unsigned = 1'b0; i_addr = '0; i_wdata = '0; model_rdata = '0;
    init_a = '0; init_d = '0;
    init_en = 1'b1;
    for (int w = 0; w < NW; w++) begin
      @(negedge clk);
      init_a = w[AW-1:0];
      init_d = $urandom;
      ref_mem[w] = init_d;
    end
    @(negedge clk);
    init_en = 1'b0;
    test_reset();
    test_store_load();
    test_errors();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
